// File: rtl/mcu_spi_bridge_pkg.sv
// rtl/mcu_spi_bridge_pkg.sv - shared types, FSM encodings and helpers for the MCU SPI bridge
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        MODE_WRITE  = 2'd0,
        MODE_READ   = 2'd1,
        MODE_DUPLEX = 2'd2
    } spi_mode_e;

    localparam logic [1:0] CMD_MODE_RSVD = 2'd3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOWER_CS = 3'd1;
    localparam logic [2:0] ST_OPCODE   = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_STALL    = 3'd4;
    localparam logic [2:0] ST_RAISE_CS = 3'd5;

    localparam logic [7:0] IDLE_TX_DEFAULT = 8'hFF;

    function automatic logic need_tx(input spi_mode_e m);
        return m != MODE_READ;
    endfunction

    function automatic logic need_rx(input spi_mode_e m);
        return m != MODE_WRITE;
    endfunction

endpackage

// File: rtl/mcu_spi_bridge_if.sv
// rtl/mcu_spi_bridge_if.sv - host command/FIFO bus and MCU SPI pins of the bridge
interface mcu_spi_bridge_if #(
    parameter int LEN_W = 9
);
    logic             CmdWr;
    logic [7:0]       CmdOpcode;
    logic [LEN_W-1:0] CmdLen;
    logic [1:0]       CmdMode;
    logic             Abort;
    logic             TxWr;
    logic [7:0]       TxData;
    logic             TxFull;
    logic             RxRd;
    logic [7:0]       RxData;
    logic             RxEmpty;
    logic             Busy;
    logic             CmdErr;
    logic             SPIDi;
    logic             SPIDo;
    logic             nMCUSel;
    logic             SPIClkRunning;
    logic             SPIClkStretch;

    modport slave (
        input  CmdWr, CmdOpcode, CmdLen, CmdMode, Abort, TxWr, TxData, RxRd, SPIDi,
        output TxFull, RxData, RxEmpty, Busy, CmdErr, SPIDo, nMCUSel,
               SPIClkRunning, SPIClkStretch
    );

    modport master (
        output CmdWr, CmdOpcode, CmdLen, CmdMode, Abort, TxWr, TxData, RxRd, SPIDi,
        input  TxFull, RxData, RxEmpty, Busy, CmdErr, SPIDo, nMCUSel,
               SPIClkRunning, SPIClkStretch
    );
endinterface

// File: rtl/mcu_spi_bridge_fifo.sv
// rtl/mcu_spi_bridge_fifo.sv - show-ahead synchronous FIFO with flush, used for TX and RX bytes
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mcu_spi_bridge.sv
// rtl/mcu_spi_bridge.sv - cart-bus to MCU SPI command bridge: opcode + counted payload via TX/RX FIFOs
module mcu_spi_bridge
    import mcu_spi_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter int         LEN_W      = 9,
    parameter logic [7:0] IDLE_TX    = IDLE_TX_DEFAULT
) (
    input  logic           SClk,
    input  logic           nReset,
    mcu_spi_bridge_if.slave bus
);
    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RX_LAST = CW'(FIFO_DEPTH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [7:0]       shreg;
    spi_mode_e        mode;
    logic             cs_n;
    logic             cmd_err;

    logic             shifting;
    logic             byte_done;
    logic [7:0]       rx_byte;
    logic             rx_push;
    logic             tx_pop;
    logic             tx_blocked;
    logic             rx_blocked;
    logic             start_byte;
    logic             accept;

    logic [7:0]       tx_head;
    logic             tx_full;
    logic [CW-1:0]    tx_count;
    logic [7:0]       rx_head;
    logic             rx_full;
    logic [CW-1:0]    rx_count;

    assign shifting  = (state == ST_OPCODE) || (state == ST_DATA);
    assign byte_done = shifting && (bit_cnt == 3'd7);
    assign rx_byte   = {shreg[6:0], bus.SPIDi};
    assign rx_push   = byte_done && (state == ST_DATA) && need_rx(mode);

    // The byte finishing this cycle still lands in RX, so the next byte needs a slot beyond it.
    assign tx_blocked = need_tx(mode) && (tx_count == '0);
    assign rx_blocked = need_rx(mode) && (rx_full || (rx_push && rx_count == RX_LAST));
    assign start_byte = (byte_done || state == ST_STALL) && (byte_cnt != '0)
                        && !tx_blocked && !rx_blocked && !bus.Abort;
    assign tx_pop     = start_byte && need_tx(mode);
    assign accept     = bus.CmdWr && (state == ST_IDLE) && (bus.CmdMode != CMD_MODE_RSVD)
                        && !bus.Abort;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (accept) state_nx = ST_LOWER_CS;
            ST_LOWER_CS: state_nx = ST_OPCODE;
            ST_OPCODE,
            ST_DATA: begin
                if (byte_done) begin
                    if (byte_cnt == '0)  state_nx = ST_RAISE_CS;
                    else if (start_byte) state_nx = ST_DATA;
                    else                 state_nx = ST_STALL;
                end
            end
            ST_STALL:    if (start_byte) state_nx = ST_DATA;
            ST_RAISE_CS: state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
        if (bus.Abort && state != ST_IDLE) state_nx = ST_RAISE_CS;
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= 8'hFF;
            mode     <= MODE_WRITE;
            cs_n     <= 1'b1;
            cmd_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            cs_n    <= !((state_nx == ST_OPCODE) || (state_nx == ST_DATA) || (state_nx == ST_STALL));
            bit_cnt <= shifting ? bit_cnt + 3'd1 : 3'd0;

            if (accept) begin
                shreg    <= bus.CmdOpcode;
                byte_cnt <= bus.CmdLen;
                mode     <= spi_mode_e'(bus.CmdMode);
            end else if (start_byte) begin
                shreg    <= need_tx(mode) ? tx_head : IDLE_TX;
                byte_cnt <= byte_cnt - LEN_W'(1);
            end else if (shifting) begin
                shreg    <= rx_byte;
            end

            if (accept) begin
                cmd_err <= 1'b0;
            end else if (bus.CmdWr && (state != ST_IDLE || bus.CmdMode == CMD_MODE_RSVD)) begin
                cmd_err <= 1'b1;
            end
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (SClk),
        .rst_n     (nReset),
        .flush     (bus.Abort),
        .push      (bus.TxWr),
        .push_data (bus.TxData),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (SClk),
        .rst_n     (nReset),
        .flush     (bus.Abort),
        .push      (rx_push),
        .push_data (rx_byte),
        .pop       (bus.RxRd),
        .pop_data  (rx_head),
        .full      (rx_full),
        .count     (rx_count)
    );

    assign bus.TxFull        = tx_full;
    assign bus.RxData        = rx_head;
    assign bus.RxEmpty       = rx_count == '0;
    assign bus.Busy          = state != ST_IDLE;
    assign bus.CmdErr        = cmd_err;
    assign bus.SPIDo         = cs_n ? 1'b1 : shreg[7];
    assign bus.nMCUSel       = cs_n;
    assign bus.SPIClkRunning = shifting;
    assign bus.SPIClkStretch = state == ST_STALL;
endmodule

// File: tb/tb_mcu_spi_bridge.sv
// tb/tb_mcu_spi_bridge.sv - directed vector bench for mcu_spi_bridge with an MCU SPI slave model
module tb_mcu_spi_bridge;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mcu_spi_bridge_if #(.LEN_W(9)) bus ();

    mcu_spi_bridge #(.FIFO_DEPTH(2), .LEN_W(9)) dut (
        .SClk   (clk),
        .nReset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MCU model: returns miso[] for data bytes, 00 during opcode, logs MOSI bytes.
    logic [7:0] miso [4];
    logic [7:0] mosi_log [$];
    logic [7:0] mon_sh;
    int         mon_bit;
    int         mon_byte;
    int         run_cnt;

    always @(negedge clk) begin
        logic [7:0] cur;
        if (bus.nMCUSel) begin
            mon_bit  = 0;
            mon_byte = 0;
            bus.SPIDi = 1'b0;
        end else if (bus.SPIClkRunning) begin
            cur = (mon_byte >= 1 && mon_byte <= 4) ? miso[mon_byte-1] : 8'h00;
            bus.SPIDi = cur[7-mon_bit];
            mon_sh = {mon_sh[6:0], bus.SPIDo};
            run_cnt++;
            if (mon_bit == 7) begin
                mosi_log.push_back(mon_sh);
                mon_byte++;
                mon_bit = 0;
            end else begin
                mon_bit++;
            end
        end
    end

    typedef struct packed {
        logic [7:0]      op;
        int              len;
        logic [1:0]      mode;
        int              ntx;
        logic [0:1][7:0] tx;
        logic [0:1][7:0] mi;
        logic [0:2][7:0] mosi;
        int              nrx;
        logic [0:1][7:0] rx;
        int              runs;
    } vec_t;

    function automatic vec_t mkv(input logic [7:0] op, input int len, input logic [1:0] md,
                                 input int ntx, input logic [15:0] tx, input logic [15:0] mi,
                                 input logic [23:0] mosi, input int nrx, input logic [15:0] rx,
                                 input int runs);
        vec_t v;
        v.op = op; v.len = len; v.mode = md; v.ntx = ntx; v.tx = tx; v.mi = mi;
        v.mosi = mosi; v.nrx = nrx; v.rx = rx; v.runs = runs;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tx_push(input logic [7:0] b);
        @(posedge clk); #1;
        bus.TxWr = 1'b1; bus.TxData = b;
        @(posedge clk); #1;
        bus.TxWr = 1'b0;
    endtask

    task automatic pulse_cmd(input logic [7:0] op, input logic [8:0] len, input logic [1:0] md);
        @(posedge clk); #1;
        bus.CmdWr = 1'b1; bus.CmdOpcode = op; bus.CmdLen = len; bus.CmdMode = md;
        @(posedge clk); #1;
        bus.CmdWr = 1'b0;
    endtask

    task automatic send_cmd(input string nm, input logic [7:0] op, input logic [8:0] len,
                            input logic [1:0] md);
        pulse_cmd(op, len, md);
        @(negedge clk);
        chk1({nm, " busy+1"}, bus.Busy, 1'b1);
        chk1({nm, " cs+1"}, bus.nMCUSel, 1'b1);
        @(negedge clk);
        chk1({nm, " cs+2"}, bus.nMCUSel, 1'b0);
        chk1({nm, " mosi bit7"}, bus.SPIDo, op[7]);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.Busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk1({nm, " done"}, bus.Busy, 1'b0);
    endtask

    task automatic wait_stretch(input string nm);
        int n = 0;
        while (!bus.SPIClkStretch && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1({nm, " stretch"}, bus.SPIClkStretch, 1'b1);
    endtask

    task automatic pop_check(input string nm, input logic [7:0] exp);
        @(negedge clk);
        chk1({nm, " rx nonempty"}, bus.RxEmpty, 1'b0);
        chk8({nm, " rxdata"}, bus.RxData, exp);
        @(posedge clk); #1;
        bus.RxRd = 1'b1;
        @(posedge clk); #1;
        bus.RxRd = 1'b0;
    endtask

    task automatic check_mosi(input string nm, input int base, input int n, input logic [39:0] exp);
        logic [39:0] e;
        e = exp;
        chki({nm, " mosi count"}, mosi_log.size() - base, n);
        for (int k = 0; k < n; k++) begin
            if (base + k < mosi_log.size())
                chk8($sformatf("%s mosi%0d", nm, k), mosi_log[base+k], e[39-8*k -: 8]);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int base;
        int rbase;
        int n;

        checks = 0;
        errors = 0;
        vecs[0] = mkv(8'h12, 2, 2'd0, 2, 16'hA53C, 16'h0000, 24'h12A53C, 0, 16'h0000, 24);
        vecs[1] = mkv(8'h20, 2, 2'd1, 0, 16'h0000, 16'h5AC3, 24'h20FFFF, 2, 16'h5AC3, 24);
        vecs[2] = mkv(8'h33, 2, 2'd2, 2, 16'h1122, 16'h9966, 24'h331122, 2, 16'h9966, 24);
        vecs[3] = mkv(8'h7E, 0, 2'd0, 0, 16'h0000, 16'h0000, 24'h7E0000, 0, 16'h0000, 8);
        vecs[4] = mkv(8'h40, 1, 2'd1, 0, 16'h0000, 16'h8100, 24'h40FF00, 1, 16'h8100, 16);
        vecs[5] = mkv(8'hB7, 1, 2'd2, 1, 16'h5C00, 16'h3A00, 24'hB75C00, 1, 16'h3A00, 16);

        rst_n = 1'b0;
        bus.CmdWr = 1'b0; bus.CmdOpcode = 8'h00; bus.CmdLen = 9'd0; bus.CmdMode = 2'd0;
        bus.Abort = 1'b0; bus.TxWr = 1'b0; bus.TxData = 8'h00; bus.RxRd = 1'b0;
        for (int k = 0; k < 4; k++) miso[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk1("rst nMCUSel", bus.nMCUSel, 1'b1);
        chk1("rst SPIDo", bus.SPIDo, 1'b1);
        chk1("rst Busy", bus.Busy, 1'b0);
        chk1("rst CmdErr", bus.CmdErr, 1'b0);
        chk1("rst Running", bus.SPIClkRunning, 1'b0);
        chk1("rst Stretch", bus.SPIClkStretch, 1'b0);
        chk1("rst TxFull", bus.TxFull, 1'b0);
        chk1("rst RxEmpty", bus.RxEmpty, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            miso[0] = vecs[i].mi[0];
            miso[1] = vecs[i].mi[1];
            base  = mosi_log.size();
            rbase = run_cnt;
            for (int k = 0; k < vecs[i].ntx; k++) tx_push(vecs[i].tx[k]);
            send_cmd($sformatf("v%0d", i), vecs[i].op, 9'(vecs[i].len), vecs[i].mode);
            wait_idle($sformatf("v%0d", i));
            check_mosi($sformatf("v%0d", i), base, vecs[i].len + 1, {vecs[i].mosi, 16'h0000});
            chki($sformatf("v%0d running", i), run_cnt - rbase, vecs[i].runs);
            for (int k = 0; k < vecs[i].nrx; k++)
                pop_check($sformatf("v%0d rx%0d", i, k), vecs[i].rx[k]);
            @(negedge clk);
            chk1($sformatf("v%0d rx drained", i), bus.RxEmpty, 1'b1);
            chk1($sformatf("v%0d tx drained", i), bus.TxFull, 1'b0);
        end

        // Duplex with one TX byte short: stretch until the host supplies it.
        miso[0] = 8'h01; miso[1] = 8'h02;
        base = mosi_log.size(); rbase = run_cnt;
        tx_push(8'hAB);
        send_cmd("stall", 8'h55, 9'd2, 2'd2);
        wait_stretch("stall");
        chk1("stall cs held", bus.nMCUSel, 1'b0);
        chki("stall bits", run_cnt - rbase, 16);
        repeat (3) @(negedge clk);
        chk1("stall still", bus.SPIClkStretch, 1'b1);
        chki("stall no shift", run_cnt - rbase, 16);
        tx_push(8'h77);
        wait_idle("stall");
        check_mosi("stall", base, 3, 40'h55AB770000);
        pop_check("stall rx0", 8'h01);
        pop_check("stall rx1", 8'h02);

        // Read len 4 into a 2-deep RX FIFO with no pops: stall after the 2nd byte.
        miso[0] = 8'h10; miso[1] = 8'h20; miso[2] = 8'h30; miso[3] = 8'h40;
        base = mosi_log.size(); rbase = run_cnt;
        send_cmd("rxfull", 8'h60, 9'd4, 2'd1);
        wait_stretch("rxfull");
        chki("rxfull bits", run_cnt - rbase, 24);
        chk1("rxfull cs held", bus.nMCUSel, 1'b0);
        pop_check("rxfull rx0", 8'h10);
        pop_check("rxfull rx1", 8'h20);
        wait_idle("rxfull");
        chki("rxfull running", run_cnt - rbase, 40);
        check_mosi("rxfull", base, 5, 40'h60FFFFFFFF);
        pop_check("rxfull rx2", 8'h30);
        pop_check("rxfull rx3", 8'h40);

        // Command errors.
        base = mosi_log.size();
        send_cmd("err", 8'hC3, 9'd0, 2'd0);
        pulse_cmd(8'h00, 9'd3, 2'd1);
        @(negedge clk);
        chk1("err busy cmd", bus.CmdErr, 1'b1);
        chk1("err still busy", bus.Busy, 1'b1);
        wait_idle("err");
        check_mosi("err", base, 1, 40'hC300000000);
        send_cmd("errclr", 8'h18, 9'd0, 2'd0);
        chk1("err cleared", bus.CmdErr, 1'b0);
        wait_idle("errclr");
        pulse_cmd(8'h00, 9'd0, 2'd3);
        @(negedge clk);
        chk1("err mode3", bus.CmdErr, 1'b1);
        chk1("err mode3 idle", bus.Busy, 1'b0);
        @(negedge clk);
        chk1("err mode3 idle2", bus.Busy, 1'b0);

        // Abort together with CmdWr in IDLE drops the command.
        @(posedge clk); #1;
        bus.CmdWr = 1'b1; bus.Abort = 1'b1; bus.CmdMode = 2'd0; bus.CmdLen = 9'd0;
        @(posedge clk); #1;
        bus.CmdWr = 1'b0; bus.Abort = 1'b0;
        @(negedge clk);
        chk1("abort+cmd idle", bus.Busy, 1'b0);
        chk1("abort+cmd cs", bus.nMCUSel, 1'b1);
        chk1("abort+cmd err kept", bus.CmdErr, 1'b1);

        // Abort in the middle of data byte 2.
        miso[0] = 8'hE1; miso[1] = 8'hE2; miso[2] = 8'hE3;
        tx_push(8'hA1);
        tx_push(8'hA2);
        send_cmd("abort", 8'h9C, 9'd3, 2'd2);
        n = 0;
        while (mon_byte != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chki("abort reach byte2", mon_byte, 2);
        tx_push(8'hB1);
        tx_push(8'hB2);
        @(negedge clk);
        chk1("abort pre txfull", bus.TxFull, 1'b1);
        chk1("abort pre rxdata", bus.RxEmpty, 1'b0);
        chk1("abort pre cs", bus.nMCUSel, 1'b0);
        @(posedge clk); #1;
        bus.Abort = 1'b1;
        @(posedge clk); #1;
        bus.Abort = 1'b0;
        @(negedge clk);
        chk1("abort cs", bus.nMCUSel, 1'b1);
        chk1("abort txfull", bus.TxFull, 1'b0);
        chk1("abort rxempty", bus.RxEmpty, 1'b1);
        chk1("abort running", bus.SPIClkRunning, 1'b0);
        wait_idle("abort");

        // Asynchronous reset in the middle of the opcode byte.
        send_cmd("rstmid", 8'hF0, 9'd0, 2'd0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rstmid cs", bus.nMCUSel, 1'b1);
        chk1("rstmid SPIDo", bus.SPIDo, 1'b1);
        chk1("rstmid Busy", bus.Busy, 1'b0);
        chk1("rstmid Running", bus.SPIClkRunning, 1'b0);
        chk1("rstmid Stretch", bus.SPIClkStretch, 1'b0);
        chk1("rstmid CmdErr", bus.CmdErr, 1'b0);
        chk1("rstmid RxEmpty", bus.RxEmpty, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rstmid stays idle", bus.Busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
